suspend_ack_ctrl: RTL



---
 rtl/suspend_ack_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/suspend_ack_ctrl.sv
// suspend_ack_ctrl
// Responder side of the suspend request/acknowledge handshake. SREQ is
// synchronized, user logic is told to quiesce, and SACK is returned only
// after IDLE has held for a guard interval. On wake, SACK drops and a
// single-cycle RESUME pulse follows after a wake interval.
//
// Optional feature macro: SUSPEND_TIMEOUT_EN
//   defined   : a drain timeout forces ACKED and sets sticky TIMEOUT_ERR
//   undefined : DRAIN waits indefinitely, TIMEOUT_ERR tied low
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no suspend in progress, user logic free to issue work
// DRAIN | QUIESCE asserted, waiting for user logic to report IDLE
// GUARD | IDLE seen, counting down the guard interval
// ACKED | SACK asserted, device suspended
// WAKE  | SREQ gone, SACK dropped, counting down to the RESUME pulse

module suspend_ack_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int GUARD_CYCLES   = 8,
    parameter int WAKE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 12
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SREQ,
    input  logic       IDLE,
    input  logic       ERR_CLR,
    output logic       SACK,
    output logic       QUIESCE,
    output logic       RESUME,
    output logic       SUSPENDED,
    output logic [2:0] STATE,
    output logic       TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_GUARD = 3'd2,
        ST_ACKED = 3'd3,
        ST_WAKE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sreq_s;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sack_q, sack_d;
    logic               quiesce_q, quiesce_d;
    logic               resume_q, resume_d;
    logic               suspended_q, suspended_d;

    logic               to_hit;
    logic               to_fire;

    // Shift SREQ through the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], SREQ};
    end

    assign sreq_s = sync_q[SYNC_STAGES-1];

    // Next-state, counter and output decode. Abort has priority over the
    // timeout, which has priority over the normal drain/guard progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sreq_s) state_d = ST_DRAIN;
            end
            ST_DRAIN, ST_GUARD: begin
                if (!sreq_s) begin
                    state_d = ST_IDLE;
                end else if (to_hit) begin
                    state_d = ST_ACKED;
                    to_fire = 1'b1;
                end else if (!IDLE) begin
                    state_d = ST_DRAIN;
                end else if (state_q == ST_DRAIN) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = ST_ACKED;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = GUARD_LD;
                    end
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ST_ACKED;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACKED: begin
                if (!sreq_s) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LD;
                end
            end
            ST_WAKE: begin
                // SREQ re-assertion is deliberately not looked at here.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sack_d      = (state_d == ST_ACKED);
        suspended_d = (state_d == ST_ACKED);
        quiesce_d   = (state_d != ST_IDLE);
        resume_d    = (state_q == ST_WAKE) && (state_d == ST_IDLE);
    end

    // FSM state, counter, synchronizer and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sack_q      <= 1'b0;
            quiesce_q   <= 1'b0;
            resume_q    <= 1'b0;
            suspended_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sack_q      <= sack_d;
            quiesce_q   <= quiesce_d;
            resume_q    <= resume_d;
            suspended_q <= suspended_d;
        end
    end

`ifdef SUSPEND_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             err_q, err_d;

    // Timeout counter runs across DRAIN and GUARD, surviving guard fallback;
    // it sits at zero otherwise so every DRAIN entry starts from zero.
    always_comb begin
        if (state_q == ST_DRAIN || state_q == ST_GUARD) begin
            tcnt_d = tcnt_q + CNT_ONE;
        end else begin
            tcnt_d = '0;
        end
        if (to_fire) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign to_hit = (tcnt_q >= TO_LAST);

    // Timeout counter and sticky error flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign TIMEOUT_ERR = err_q;
`else
    logic [2:0] unused_sigs;

    assign to_hit      = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
    assign unused_sigs = {ERR_CLR, to_fire, (TIMEOUT_CYCLES > 0)};
`endif

    assign SACK      = sack_q;
    assign QUIESCE   = quiesce_q;
    assign RESUME    = resume_q;
    assign SUSPENDED = suspended_q;
    assign STATE     = state_q;

endmodule
